// File: rtl/ddr_arb_pkg.sv
// Shared constants for the DDR request arbiter: command opcodes, client
// indices and the arbiter FSM state encoding.
package ddr_arb_pkg;

  localparam int unsigned N_REQ  = 5;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned TAG_W  = 3;

  localparam logic [OP_W-1:0] CMD_RD = 4'b0011;
  localparam logic [OP_W-1:0] CMD_WR = 4'b0100;

  localparam int unsigned CL_CAM  = 0;
  localparam int unsigned CL_HDRW = 1;
  localparam int unsigned CL_HDRR = 2;
  localparam int unsigned CL_VGA  = 3;
  localparam int unsigned CL_UART = 4;

  typedef enum logic [0:0] {
    WAIT_INIT = 1'b0,
    RUN       = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ddr_req_arbiter_rr_pick4.sv
// Combinational 4-way round-robin picker.
//   elig  : eligibility, bit j = candidate j
//   ptr   : candidate index where the search starts (wraps 3 -> 0)
//   grant : one-hot winner
//   found : at least one candidate was eligible
module rr_pick4 (
  input  logic [3:0] elig,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic       found
);

  logic [1:0] idx;

  // First eligible candidate at or after ptr, modulo 4.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Five-client DDR command arbiter. Camera write has strict priority, the
// other four clients share round-robin, and a per-client starvation counter
// lets a round-robin client pre-empt camera once after waiting too long.
// Grants are valid/ready handshakes; the accepted request is registered
// onto cmd_* one cycle later, and reads also push their client ID into the
// read-return routing FIFO.
//   clk_133M, rst_133M : clock, synchronous active-high reset
//   init_done          : DDR calibration complete
//   req_*              : packed per-client request bus, req_ready = grant
//   cmd_*              : command to the downstream command FIFO
//   tag_*              : read-return routing FIFO push / full
module ddr_req_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned STARVE_LIM = 64
) (
  input  logic                      clk_133M,
  input  logic                      rst_133M,
  input  logic                      init_done,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_is_wr,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [OP_W-1:0]           cmd_op,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [DATA_W-1:0]         cmd_wdata,
  output logic                      tag_push,
  output logic [TAG_W-1:0]          tag_id,
  input  logic                      tag_full
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

  arb_state_e         state_q, state_d;
  logic [2:0]         rr_ptr;
  logic [CNT_W-1:0]   starve_cnt [1:N_REQ-1];

  logic               slot_free;
  logic               arb_en;
  logic               starved;
  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   grant;
  logic [3:0]         rr_grant;
  logic               rr_found;
  logic [TAG_W-1:0]   win_idx;
  logic               win_is_wr;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  assign slot_free = ~cmd_valid | cmd_ready;
  // Reads need room in the routing FIFO; writes never do.
  assign elig      = req_valid & (req_is_wr | {N_REQ{~tag_full}});
  // Reset suppresses grants so nothing is accepted and then discarded.
  assign arb_en    = (state_q == RUN) & slot_free & ~rst_133M;

  rr_pick4 u_rr_pick4 (
    .elig  (elig[N_REQ-1:1]),
    .ptr   (2'(rr_ptr - 3'd1)),
    .grant (rr_grant),
    .found (rr_found)
  );

  // Any round-robin client that has waited STARVE_LIM camera grants.
  always_comb begin
    starved = 1'b0;
    for (int i = 1; i < int'(N_REQ); i++) begin
      if (starve_cnt[i] >= CNT_W'(STARVE_LIM)) starved = 1'b1;
    end
  end

  // Winner selection: starved round-robin > camera > round-robin.
  always_comb begin
    grant = '0;
    if (arb_en) begin
      if (starved && rr_found)  grant = {rr_grant, 1'b0};
      else if (elig[CL_CAM])    grant[CL_CAM] = 1'b1;
      else if (rr_found)        grant = {rr_grant, 1'b0};
    end
  end

  assign req_ready = grant;

  // One-hot grant to index, then mux the winning request.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant[i]) win_idx = TAG_W'(i);
    end
  end

  assign win_is_wr = req_is_wr[win_idx];
  assign win_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata[win_idx*DATA_W +: DATA_W];

  // FSM state register.
  always_ff @(posedge clk_133M) begin
    if (rst_133M) state_q <= WAIT_INIT;
    else          state_q <= state_d;
  end

  // FSM next state: run only while calibration holds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_INIT: if (init_done)  state_d = RUN;
      RUN:       if (!init_done) state_d = WAIT_INIT;
      default:                   state_d = WAIT_INIT;
    endcase
  end

  // Command output register; holds while stalled, tag_push is a one-cycle pulse.
  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      tag_push  <= 1'b0;
      tag_id    <= '0;
    end else begin
      tag_push <= 1'b0;
      if (|grant) begin
        cmd_valid <= 1'b1;
        cmd_op    <= win_is_wr ? CMD_WR : CMD_RD;
        cmd_addr  <= win_addr;
        cmd_wdata <= win_is_wr ? win_wdata : '0;
        tag_push  <= ~win_is_wr;
        tag_id    <= win_idx;
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer: next search starts just past the last RR winner.
  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      rr_ptr <= 3'd1;
    end else if (|grant[N_REQ-1:1]) begin
      rr_ptr <= (win_idx == 3'(CL_UART)) ? 3'd1 : win_idx + 3'd1;
    end
  end

  // Starvation counters: count camera wins while waiting eligible.
  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      for (int i = 1; i < int'(N_REQ); i++) starve_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < int'(N_REQ); i++) begin
        if (!req_valid[i] || grant[i]) begin
          starve_cnt[i] <= '0;
        end else if (elig[i] && grant[CL_CAM] &&
                     starve_cnt[i] != CNT_W'(STARVE_LIM)) begin
          starve_cnt[i] <= starve_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Self-checking bench for ddr_req_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_ddr_req_arbiter;

  localparam int NR   = 5;
  localparam int AW   = 25;
  localparam int DW   = 128;
  localparam int SLIM = 64;

  logic              clk_133M = 1'b0;
  logic              rst_133M;
  logic              init_done;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_is_wr;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
  logic              tag_push;
  logic [2:0]        tag_id;
  logic              tag_full;

  ddr_req_arbiter dut (
    .clk_133M  (clk_133M),
    .rst_133M  (rst_133M),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_is_wr (req_is_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .tag_push  (tag_push),
    .tag_id    (tag_id),
    .tag_full  (tag_full)
  );

  always #4 clk_133M = ~clk_133M;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (reset values).
  bit          m_run   = 1'b0;
  int          m_rr    = 1;
  int          m_cnt [NR];
  bit          m_valid = 1'b0;
  logic [3:0]  m_op    = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit          m_push  = 1'b0;
  logic [2:0]  m_tid   = '0;
  int          obs_grant;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_rr = 1; m_valid = 1'b0; m_op = '0; m_addr = '0;
    m_wdata = '0; m_push = 1'b0; m_tid = '0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
  endtask

  // One clock: compare outputs and grant against the model, then advance it.
  task automatic tick();
    int g, rrw, c;
    bit slot, run, starved;
    bit [NR-1:0] el;
    logic [NR-1:0] exp_rdy;
    @(negedge clk_133M);
    check("cmd_valid", 128'(cmd_valid), 128'(m_valid));
    check("cmd_op",    128'(cmd_op),    128'(m_op));
    check("cmd_addr",  128'(cmd_addr),  128'(m_addr));
    check("cmd_wdata", cmd_wdata,       m_wdata);
    check("tag_push",  128'(tag_push),  128'(m_push));
    check("tag_id",    128'(tag_id),    128'(m_tid));

    slot = !m_valid || cmd_ready;
    run  = m_run && !rst_133M;
    for (int i = 0; i < NR; i++) el[i] = req_valid[i] && (req_is_wr[i] || !tag_full);
    starved = 1'b0;
    for (int i = 1; i < NR; i++) if (m_cnt[i] >= SLIM) starved = 1'b1;
    rrw = -1;
    for (int k = 0; k < 4; k++) begin
      c = ((m_rr - 1 + k) % 4) + 1;
      if (rrw < 0 && el[c]) rrw = c;
    end
    g = -1;
    if (run && slot) begin
      if (starved && rrw >= 0) g = rrw;
      else if (el[0])          g = 0;
      else                     g = rrw;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 128'(req_ready), 128'(exp_rdy));
    obs_grant = -1;
    for (int i = 0; i < NR; i++) if (req_ready[i] === 1'b1) obs_grant = i;

    if (rst_133M) begin
      model_reset();
    end else begin
      for (int i = 1; i < NR; i++) begin
        if (!req_valid[i] || g == i) m_cnt[i] = 0;
        else if (el[i] && g == 0 && m_cnt[i] < SLIM) m_cnt[i]++;
      end
      if (g >= 1) m_rr = (g == 4) ? 1 : g + 1;
      m_push = 1'b0;
      if (g >= 0) begin
        m_valid = 1'b1;
        m_op    = req_is_wr[g] ? 4'b0100 : 4'b0011;
        m_addr  = req_addr[g*AW +: AW];
        m_wdata = req_is_wr[g] ? req_wdata[g*DW +: DW] : '0;
        m_push  = !req_is_wr[g];
        m_tid   = 3'(g);
      end else if (cmd_ready) begin
        m_valid = 1'b0;
      end
      if (!m_run && init_done)      m_run = 1'b1;
      else if (m_run && !init_done) m_run = 1'b0;
    end
    @(posedge clk_133M);
    #1;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = AW'($urandom());
      req_wdata[i*DW +: DW] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  initial begin
    int exp_seq [5];
    int hit, pushes;
    exp_seq = '{1, 2, 3, 4, 1};
    model_reset();

    rst_133M  = 1'b1;
    init_done = 1'b0;
    req_valid = '1;
    req_is_wr = 5'b00011;
    cmd_ready = 1'b1;
    tag_full  = 1'b0;
    randomize_payload();
    repeat (2) @(posedge clk_133M);
    #1;

    // Reset and pre-calibration: nothing granted.
    repeat (2) tick();
    rst_133M = 1'b0;
    repeat (3) tick();
    check("precal_ready", 128'(req_ready), 128'(0));
    init_done = 1'b1;
    tick();
    tick();
    check("cam_first_op", 128'(cmd_op), 128'(4'b0100));
    tick();

    // Round-robin among 1..4 with camera idle.
    req_valid = 5'b11110;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("rr_order", 128'(obs_grant), 128'(exp_seq[t]));
    end

    // Starvation: VGA pre-empts camera on its 65th eligible cycle.
    req_valid = 5'b01001;
    hit = 0;
    for (int t = 1; t <= 100 && hit == 0; t++) begin
      tick();
      if (obs_grant == 3) hit = t;
    end
    check("starve_cycle", 128'(hit), 128'(65));
    tick();
    check("cam_resumes", 128'(obs_grant), 128'(0));

    // Stall with a held VGA read.
    req_valid = 5'b01000;
    req_addr[3*AW +: AW] = 25'h0001234;
    tick();
    pushes = int'(tag_push);
    cmd_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      pushes += int'(tag_push);
      check("stall_addr", 128'(cmd_addr), 128'(25'h0001234));
    end
    check("stall_pushes", 128'(pushes), 128'(1));
    cmd_ready = 1'b1;
    req_valid = '0;
    tick();

    // Routing FIFO full blocks the UART read, not the HDR write.
    tag_full  = 1'b1;
    req_valid = 5'b10010;
    for (int t = 0; t < 3; t++) begin
      tick();
      check("full_hdrw", 128'(obs_grant), 128'(1));
    end
    tag_full = 1'b0;
    tick();
    check("unfull_uart", 128'(obs_grant), 128'(4));

    // Reset while a command is held.
    req_valid = 5'b00001;
    cmd_ready = 1'b0;
    tick();
    rst_133M = 1'b1;
    tick();
    check("rst_cmd_valid", 128'(cmd_valid), 128'(0));
    check("rst_cmd_addr",  128'(cmd_addr),  128'(0));
    rst_133M  = 1'b0;
    cmd_ready = 1'b1;
    tick();

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      rst_133M  = ($urandom_range(0, 299) == 0);
      init_done = ($urandom_range(0, 39) != 0);
      req_valid[0] = ($urandom_range(0, 9) < 8);
      for (int i = 1; i < NR; i++) req_valid[i] = ($urandom_range(0, 1) == 1);
      cmd_ready = ($urandom_range(0, 3) != 0);
      tag_full  = ($urandom_range(0, 4) == 0);
      randomize_payload();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
